// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             wafull,
  output logic             raempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] C_FULL = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] C_AF   = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] C_AE   = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] C_ONE  = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] P_ONE = ASIZE'(1);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             w_wr;
  logic             w_rd;

  // Flags come only from the registered count.
  assign wfull     = (r_count == C_FULL);
  assign rempty    = (r_count == '0);
  assign wafull    = (r_count >= C_AF);
  assign raempty   = (r_count <= C_AE);
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

  assign w_wr = winc && !wfull;
  assign w_rd = rinc && !rempty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + P_ONE;
      if (w_rd) r_rptr <= r_rptr + P_ONE;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (winc && wfull) r_ovf <= 1'b1;
      else if (err_clr)  r_ovf <= 1'b0;
      if (rinc && rempty) r_unf <= 1'b1;
      else if (err_clr)   r_unf <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign rdata = r_mem[r_rptr];
`else
  logic [DSIZE-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (w_rd) r_rdata <= r_mem[r_rptr];
  end

  assign rdata = r_rdata;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: queue reference model,
// directed scenarios followed by randomized traffic.
module tb_sync_fifo_flags;

  localparam int DSIZE = 8;
  localparam int ASIZE = 3;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic             err_clr;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             wafull;
  logic             raempty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  sync_fifo_flags #(
    .DSIZE(DSIZE), .ASIZE(ASIZE),
    .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wdata(wdata), .winc(winc), .rinc(rinc),
    .err_clr(err_clr), .rdata(rdata),
    .wfull(wfull), .rempty(rempty),
    .wafull(wafull), .raempty(raempty),
    .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: stored words, read results awaiting the monitor.
  logic [DSIZE-1:0] m_q [$];
  logic [DSIZE-1:0] exp_q [$];
  logic [DSIZE-1:0] m_rdata;
  logic             m_ovf;
  logic             m_unf;
  logic             m_pend;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    exp_q.delete();
    m_rdata = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_pend  = 1'b0;
  endtask

  // Apply the FIFO rules to the inputs present at this clock edge.
  task automatic model_step();
    bit full, empty;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    if (winc && full) m_ovf = 1'b1;
    else if (err_clr) m_ovf = 1'b0;
    if (rinc && empty) m_unf = 1'b1;
    else if (err_clr)  m_unf = 1'b0;
    m_pend = 1'b0;
    if (rinc && !empty) begin
      exp_q.push_back(m_q.pop_front());
      m_pend = 1'b1;
    end
    if (winc && !full) m_q.push_back(wdata);
  endtask

  task automatic cyc(input bit w, input bit r,
                     input logic [DSIZE-1:0] d,
                     input bit clr);
    winc = w; rinc = r; wdata = d; err_clr = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    winc = 0; rinc = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    winc = 0; rinc = 0; err_clr = 0; wdata = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: flags every cycle, data whenever a word is presented.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("count", 32'(count), 32'(m_q.size()));
      chk("wfull", 32'(wfull), 32'(m_q.size() == DEPTH));
      chk("rempty", 32'(rempty), 32'(m_q.size() == 0));
      chk("wafull", 32'(wafull), 32'(m_q.size() >= AF_TH));
      chk("raempty", 32'(raempty), 32'(m_q.size() <= AE_TH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
      if (!rempty && m_q.size() != 0)
        chk("fwft_rdata", 32'(rdata), 32'(m_q[0]));
`else
      if (m_pend && exp_q.size() != 0) begin
        m_rdata = exp_q.pop_front();
        m_pend  = 1'b0;
        chk("rdata", 32'(rdata), 32'(m_rdata));
      end else begin
        chk("rdata_hold", 32'(rdata), 32'(m_rdata));
      end
`endif
    end
  end

  initial begin
    rst_n = 1'b0;
    winc = 0; rinc = 0; err_clr = 0; wdata = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Reset with five words stored.
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h40 + i), 0);
    do_reset();

    // Fill with 0x11..0x88, then drain.
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i * 8'h11), 0);
    // Write while full (overflow), then read+write while full.
    cyc(1, 0, 8'h99, 0);
    cyc(1, 1, 8'h99, 0);
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'h00, 0);

    // Read while empty, then simultaneous access on empty.
    cyc(0, 1, 8'h00, 0);
    cyc(0, 1, 8'h00, 1);
    cyc(1, 1, 8'h5A, 0);
    cyc(0, 1, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);

    // FWFT head visibility on a single write into empty.
    cyc(1, 0, 8'hA5, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h00, 0);

    // Steady occupancy of 4 with continuous streaming.
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 20; i++) cyc(1, 1, 8'(i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00, 0);

    // Random traffic with phases biased to fill and to drain.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 150; i++) begin
        bit w, r, c;
        w = ($urandom_range(0, 99) < ((p % 2 == 0) ? 75 : 30));
        r = ($urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 75));
        c = ($urandom_range(0, 7) == 0);
        cyc(w, r, 8'($urandom), c);
      end
      if (p == 4) do_reset();
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
